// File: rtl/alu_result_fifo_if.sv
// Valid/ready handshake bundle between the ALU, the result FIFO and its consumer.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface alu_result_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_carry;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic [2:0]       out_op;

  modport master (
    output in_valid, in_y, in_carry, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_carry, out_zero, out_neg, out_op
  );

  modport slave (
    input  in_valid, in_y, in_carry, in_op, out_ready,
    output in_ready, out_valid, out_y, out_carry, out_zero, out_neg, out_op
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 8-bit ALU: stores {op, carry, neg, zero, y} per entry.
// Optional statistics counters are enabled by defining ALU_RESULT_STATS_EN.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     op_err
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]              carry_cnt,
  output logic [15:0]              result_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic             carry;
    logic             neg;
    logic             zero;
    logic [WIDTH-1:0] y;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  entry_t        head;
  entry_t        new_entry;

  // Flow control depends only on registered count, so out_ready never reaches in_ready.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign new_entry.op    = bus.in_op;
  assign new_entry.carry = bus.in_carry;
  assign new_entry.neg   = bus.in_y[WIDTH-1];
  assign new_entry.zero  = (bus.in_y == '0);
  assign new_entry.y     = bus.in_y;

  assign head          = mem[rd_ptr];
  assign bus.out_y     = head.y;
  assign bus.out_carry = head.carry;
  assign bus.out_zero  = head.zero;
  assign bus.out_neg   = head.neg;
  assign bus.out_op    = head.op;

  // Storage is deliberately not reset; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      op_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && (bus.in_op >= 3'd5)) begin
        op_err <= 1'b1;
      end
    end
  end

`ifdef ALU_RESULT_STATS_EN
  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt  <= '0;
      result_cnt <= '0;
    end else if (push) begin
      if (result_cnt != 16'hFFFF) begin
        result_cnt <= result_cnt + 16'd1;
      end
      if (bus.in_carry && (carry_cnt != 16'hFFFF)) begin
        carry_cnt <= carry_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  logic       op_err;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0] carry_cnt;
  logic [15:0] result_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_result_fifo_if #(.WIDTH(WIDTH)) bus ();

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .count      (count),
    .op_err     (op_err)
`ifdef ALU_RESULT_STATS_EN
    ,
    .carry_cnt  (carry_cnt),
    .result_cnt (result_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       carry;
    logic [2:0] op;
  } result_t;

  result_t model_q[$];
  logic    model_err;
  int      model_carry;
  int      model_result;

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] y;
    logic       c;
    logic [2:0] op;
    int         e_cnt;
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_y;
    logic       e_c;
    logic       e_z;
    logic       e_n;
    logic [2:0] e_op;
  } vec_t;

  vec_t vecs[12];

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    result_t h;
    check_value("count", 32'(count), 32'(model_q.size()));
    check_value("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
    check_value("in_ready", 32'(bus.in_ready), 32'(model_q.size() != DEPTH));
    check_value("op_err", 32'(op_err), 32'(model_err));
    if (model_q.size() != 0) begin
      h = model_q[0];
      check_value("out_y", 32'(bus.out_y), 32'(h.y));
      check_value("out_carry", 32'(bus.out_carry), 32'(h.carry));
      check_value("out_zero", 32'(bus.out_zero), 32'(h.y == 8'h00));
      check_value("out_neg", 32'(bus.out_neg), 32'(h.y[7]));
      check_value("out_op", 32'(bus.out_op), 32'(h.op));
    end
`ifdef ALU_RESULT_STATS_EN
    check_value("carry_cnt", 32'(carry_cnt), 32'(model_carry));
    check_value("result_cnt", 32'(result_cnt), 32'(model_result));
`endif
  endtask

  // One clock of traffic: decide the handshakes from the model, advance, then compare.
  task automatic apply_stimulus();
    bit      do_push;
    bit      do_pop;
    result_t e;
    do_push = bus.in_valid && (model_q.size() < DEPTH);
    do_pop  = bus.out_ready && (model_q.size() > 0);
    e.y = bus.in_y;
    e.carry = bus.in_carry;
    e.op = bus.in_op;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      model_err = 1'b0;
      model_carry = 0;
      model_result = 0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(e);
        if (e.op >= 3'd5) model_err = 1'b1;
        if (model_result < 65535) model_result++;
        if (e.carry && model_carry < 65535) model_carry++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_input(input logic v, input logic [7:0] y, input logic c, input logic [2:0] op);
    bus.in_valid = v;
    bus.in_y = y;
    bus.in_carry = c;
    bus.in_op = op;
  endtask

  task automatic drive_random(input bit allow_bad_op);
    drive_input(1'b1, 8'($urandom), 1'($urandom),
                allow_bad_op ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4)));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_input(1'b1, 8'hAA, 1'b1, 3'd6);
    bus.out_ready = 1'b1;
    apply_stimulus();
    rst_n = 1'b1;
    drive_input(1'b0, 8'h00, 1'b0, 3'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h81, 1'b1, 3'd0, 1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'h02, 1'b0, 3'd1, 2, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 8'h03, 1'b0, 3'd3, 3, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 8'h04, 1'b1, 3'd4, 4, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 8'h55, 1'b0, 3'd1, 4, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 3, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 2, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 3'd4};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 3'd2, 1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2};

    drive_input(1'b0, 8'h00, 1'b0, 3'd0);
    bus.out_ready = 1'b0;
    model_err = 1'b0;
    model_carry = 0;
    model_result = 0;
    @(negedge clk);
    reset_dut();

    // Directed table: push/pop order, full back-pressure and empty boundary.
    for (int i = 0; i < 12; i++) begin
      drive_input(vecs[i].v, vecs[i].y, vecs[i].c, vecs[i].op);
      bus.out_ready = vecs[i].r;
      @(posedge clk);
      @(negedge clk);
      check_value($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      check_value($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check_value($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      check_value($sformatf("vec%0d_op_err", i), 32'(op_err), 32'(0));
      if (vecs[i].e_ov) begin
        check_value($sformatf("vec%0d_out_y", i), 32'(bus.out_y), 32'(vecs[i].e_y));
        check_value($sformatf("vec%0d_out_carry", i), 32'(bus.out_carry), 32'(vecs[i].e_c));
        check_value($sformatf("vec%0d_out_zero", i), 32'(bus.out_zero), 32'(vecs[i].e_z));
        check_value($sformatf("vec%0d_out_neg", i), 32'(bus.out_neg), 32'(vecs[i].e_n));
        check_value($sformatf("vec%0d_out_op", i), 32'(bus.out_op), 32'(vecs[i].e_op));
      end
    end

    // Full FIFO with both sides active: no loss across pointer wrap.
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      drive_random(1'b0);
      apply_stimulus();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_random(1'b0);
      apply_stimulus();
      check_value("full_drain_count_range", 32'((count == 3'd3) || (count == 3'd4)), 32'(1));
    end

    // Streaming from empty: occupancy settles at one.
    reset_dut();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_random(1'b0);
      apply_stimulus();
      check_value("stream_count", 32'(count), 32'(1));
    end

    // Sticky op_err, cleared only by reset.
    reset_dut();
    drive_input(1'b1, 8'h10, 1'b0, 3'd6);
    apply_stimulus();
    check_value("op_err_set", 32'(op_err), 32'(1));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random(1'b0);
      apply_stimulus();
    end
    check_value("op_err_sticky", 32'(op_err), 32'(1));
    reset_dut();
    check_value("op_err_cleared", 32'(op_err), 32'(0));
    check_value("reset_count", 32'(count), 32'(0));
    check_value("reset_out_valid", 32'(bus.out_valid), 32'(0));

    // Randomized traffic with varying pressure on both sides.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_random(1'b1);
      else drive_input(1'b0, 8'($urandom), 1'b0, 3'd0);
      bus.out_ready = (i % 100 < 50) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0);
      apply_stimulus();
    end

`ifdef ALU_RESULT_STATS_EN
    reset_dut();
    bus.out_ready = 1'b0;
    drive_input(1'b1, 8'h01, 1'b1, 3'd0);
    apply_stimulus();
    drive_input(1'b1, 8'h02, 1'b0, 3'd0);
    apply_stimulus();
    drive_input(1'b1, 8'h03, 1'b1, 3'd0);
    apply_stimulus();
    check_value("stats_carry_cnt", 32'(carry_cnt), 32'(2));
    check_value("stats_result_cnt", 32'(result_cnt), 32'(3));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive_input(1'b1, 8'(i), 1'(i), 3'd1);
      apply_stimulus();
    end
    check_value("stats_result_sat", 32'(result_cnt), 32'(16'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream result stage for the 8-bit combinational ALU. Captures each ALU result (`y`, `carry`) with the opcode that produced it and adds zero and negative flags. Buffers up to DEPTH entries in a synchronous FIFO and presents them to the consumer (register-file writeback or the power-trace logger) through a valid/ready handshake. Isolates the combinational ALU from consumer back-pressure.

## Interface
- `WIDTH`, 8: result width; matches ALU `y`.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: the ALU result on `in_y`/`in_carry`/`in_op` is valid.
- `in_ready` output 1: the FIFO can accept an entry this cycle.
- `in_y` input WIDTH: ALU result.
- `in_carry` input 1: ALU carry/borrow bit.
- `in_op` input 3: opcode applied to the ALU for this result.
- `out_valid` output 1: the head entry is valid.
- `out_ready` input 1: the consumer accepts the head entry.
- `out_y` output WIDTH: head result.
- `out_carry` output 1: head carry.
- `out_zero` output 1: head `y == 0`.
- `out_neg` output 1: head `y[WIDTH-1]`.
- `out_op` output 3: head opcode.
- `count` output $clog2(DEPTH)+1: number of occupied entries.
- `op_err` output 1: sticky flag; an accepted entry had `in_op` in 5..7.
- `carry_cnt` output 16: present only with the macro; number of accepted entries with carry set.
- `result_cnt` output 16: present only with the macro; number of accepted entries.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {op, carry, neg, zero, y}.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Push: `in_valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- `zero` and `neg` are computed from `in_y` at push time and stored with the entry. They are not recomputed at the output.
- Pop: `out_valid && out_ready`. Then `rd_ptr` increments.
- `in_ready = (count != DEPTH)`.
- `out_valid = (count != 0)`.
- `out_*` are read combinationally from the entry at `rd_ptr`. Values are don't-care while `out_valid` = 0.
- `count` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when both or neither occur.
- Full (count == DEPTH): `in_ready` = 0, so no push. A pop in the same cycle frees one slot; `in_ready` rises the next cycle. There is no same-cycle full pass-through.
- Empty (count == 0): no pop. There is no combinational bypass; a pushed entry is first visible the cycle after the push.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and `count` is unchanged.
- `in_valid` with `in_ready` = 0: the input is ignored and upstream must hold it. The FIFO does not flag this.
- `op_err`: set on any push with `in_op` ≥ 5. The entry is still stored. The flag clears only on reset.
- Reset mid-operation: all buffered entries are discarded, and no pop or push occurs in the reset cycle.

## Timing
- Registered outputs and values while `rst_n` = 0 at a clock edge:
  - `count` = 0, pointers = 0, `op_err` = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - `carry_cnt` = 0, `result_cnt` = 0.
- `out_y`, `out_carry`, `out_zero`, `out_neg` and `out_op` are combinational reads of the array and have no reset value. They are don't-care while `out_valid` = 0; the array itself is not reset.
- Latency: a push at edge N gives `out_valid` = 1 with that data in the cycle after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Handshake: the consumer may assert `out_ready` at any time. `out_*` are stable while `out_valid && !out_ready`.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- Macro: `ALU_RESULT_STATS_EN`.
- Defined:
  - `carry_cnt` increments on each push with `in_carry` = 1.
  - `result_cnt` increments on each push.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the `carry_cnt` and `result_cnt` ports and their logic are absent.

## Test plan
- Reset, then push y=8'h00, carry=0, op=3'b010 with `out_ready` = 0:
  - next cycle `out_valid` = 1, `out_zero` = 1, `out_neg` = 0, `count` = 1.
- Push 4 entries (y = 8'h81, 8'h02, 8'h03, 8'h04) with `out_ready` = 0:
  - `in_ready` = 0 and `count` = 4.
  - a 5th `in_valid` is ignored.
  - popping 4 entries yields 81 (`out_neg` = 1), 02, 03, 04 in order.
- Fill to full, then hold `in_valid` and `out_ready` high for 10 cycles:
  - alternating pop/push with no loss.
  - after the first drain cycle, `count` stays at 3 or 4; order is preserved across pointer wrap.
- Stream 20 entries with `in_valid` and `out_ready` both held high:
  - one pop per cycle after the first.
  - `count` stays at 1.
  - data matches the input sequence.
- Push op=3'b110:
  - `op_err` = 1 and stays 1 after further valid ops.
  - `rst_n` = 0 for one edge clears `op_err` and `count` and drops `out_valid`.
- With `ALU_RESULT_STATS_EN`, push 3 entries with carry = 1,0,1:
  - `carry_cnt` = 2, `result_cnt` = 3.
  - forcing 65,536 pushes leaves `result_cnt` at 16'hFFFF.
